// File: rtl/nic_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : nic_endpoint
// Purpose  : Processor-side NIC responder with one single-entry input channel
//            buffer (router -> processor) and one single-entry output channel
//            buffer (processor -> router), each with a full flag.
// Ports    :
//   clk, rst          - clock, asynchronous active-high reset
//   addr              - register select: 00 in_buf, 01 in status,
//                       10 out_buf, 11 out status
//   d_in / d_out      - processor store data / registered load data
//   nicEn, nicEnWr    - access enable, 1 = store / 0 = load
//   net_si/ri/di      - router -> NIC valid / ready / data
//   net_so/ro/do      - NIC -> router valid pulse / ready / data
//   net_polarity      - router VC phase; a packet leaves only when its
//                       top (VC) bit differs from the current polarity
// Revision : 1.0 - initial release
// ============================================================================
module nic_endpoint #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_IN_BUF  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_IN_STS  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_OUT_BUF = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_OUT_STS = ADDR_WIDTH'(3);

  logic [DATA_WIDTH-1:0] r_in_buf;
  logic                  r_in_full;
  logic [DATA_WIDTH-1:0] r_out_buf;
  logic                  r_out_full;
  logic [DATA_WIDTH-1:0] r_d_out;
  logic                  r_net_so;
  logic [DATA_WIDTH-1:0] r_net_do;

  logic                  w_load;
  logic                  w_store;
  logic                  w_drain;
  logic                  w_arrive;
  logic                  w_send;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_load   = nicEn & ~nicEnWr;
  // A store only lands in an empty output buffer; a full buffer drops it.
  assign w_store  = nicEn & nicEnWr & (addr == c_ADDR_OUT_BUF) & ~r_out_full;
  assign w_drain  = w_load & (addr == c_ADDR_IN_BUF) & r_in_full;
  // Arrival requires an empty buffer, so it can never coincide with a drain;
  // a packet offered during a drain cycle is taken on the following edge.
  assign w_arrive = net_si & ~r_in_full;
  // Send requires out_full, so it can never coincide with an accepted store.
  assign w_send   = r_out_full & net_ro & (r_out_buf[DATA_WIDTH-1] != net_polarity);

  // Status reads use the pre-edge flag values.
  always_comb begin
    w_load_data = '0;
    case (addr)
      c_ADDR_IN_BUF:  w_load_data = r_in_buf;
      c_ADDR_IN_STS:  w_load_data = {{(DATA_WIDTH-1){1'b0}}, r_in_full};
      c_ADDR_OUT_STS: w_load_data = {{(DATA_WIDTH-1){1'b0}}, r_out_full};
      default:        w_load_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_buf   <= '0;
      r_in_full  <= 1'b0;
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
      r_d_out    <= '0;
      r_net_so   <= 1'b0;
      r_net_do   <= '0;
    end else begin
      if (w_load) begin
        r_d_out <= w_load_data;
      end

      if (w_arrive) begin
        r_in_buf  <= net_di;
        r_in_full <= 1'b1;
      end else if (w_drain) begin
        r_in_full <= 1'b0;
      end

      if (w_store) begin
        r_out_buf  <= d_in;
        r_out_full <= 1'b1;
      end else if (w_send) begin
        r_out_full <= 1'b0;
      end

      // Clearing out_full on the send edge guarantees a one-cycle pulse.
      r_net_so <= w_send;
      if (w_send) begin
        r_net_do <= r_out_buf;
      end
    end
  end

  assign net_ri = ~r_in_full;
  assign d_out  = r_d_out;
  assign net_so = r_net_so;
  assign net_do = r_net_do;

endmodule
`default_nettype wire

// File: tb/tb_nic_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_nic_endpoint
// Purpose  : Self-checking bench for nic_endpoint: a table of per-cycle
//            stimulus/expected-output records followed by a hand-written
//            asynchronous-reset sequence with both buffers full.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nic_endpoint;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 2;
  localparam int NVEC       = 26;

  localparam logic [63:0] c_P  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] c_P2 = 64'h8000_0000_0000_1234;
  localparam logic [63:0] c_A  = 64'h0000_0000_0000_00AA;
  localparam logic [63:0] c_D  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] c_F  = 64'h0000_0000_0000_0055;
  localparam logic [63:0] c_X  = 64'h0000_0000_0000_FFFF;

  logic                  clk;
  logic                  rst;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicEnWr;
  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_polarity;

  int total;
  int bad;

  typedef struct {
    logic        en;
    logic        wr;
    logic [1:0]  a;
    logic [63:0] din;
    logic        si;
    logic [63:0] di;
    logic        ro;
    logic        pol;
    logic [63:0] e_dout;
    logic        e_so;
    logic [63:0] e_do;
    logic        e_ri;
  } vec_t;

  vec_t vecs [NVEC];

  nic_endpoint #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .d_in        (d_in),
    .d_out       (d_out),
    .nicEn       (nicEn),
    .nicEnWr     (nicEnWr),
    .net_si      (net_si),
    .net_ri      (net_ri),
    .net_di      (net_di),
    .net_so      (net_so),
    .net_ro      (net_ro),
    .net_do      (net_do),
    .net_polarity(net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic wr, input logic [1:0] a,
                              input logic [63:0] din, input logic si, input logic [63:0] di,
                              input logic ro, input logic pol, input logic [63:0] e_dout,
                              input logic e_so, input logic [63:0] e_do, input logic e_ri);
    vec_t v;
    v.en = en; v.wr = wr; v.a = a; v.din = din; v.si = si; v.di = di;
    v.ro = ro; v.pol = pol; v.e_dout = e_dout; v.e_so = e_so; v.e_do = e_do; v.e_ri = e_ri;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                       input logic si, input logic [63:0] di, input logic ro, input logic pol);
    nicEn = en; nicEnWr = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b0, 1'b0);

    //             en wr  a   din   si  di   ro pol  e_dout e_so e_do  e_ri
    vecs[0]  = mk(0, 0, 2'd0, 0,    0, 0,    0, 0,  0,     0,   0,    1); // idle
    vecs[1]  = mk(1, 1, 2'd2, c_P,  0, 0,    0, 0,  0,     0,   0,    1); // store P, router busy
    vecs[2]  = mk(1, 0, 2'd3, 0,    0, 0,    0, 0,  1,     0,   0,    1); // out status = 1
    vecs[3]  = mk(0, 0, 2'd0, 0,    0, 0,    1, 0,  1,     0,   0,    1); // VC bit == polarity: hold
    vecs[4]  = mk(0, 0, 2'd0, 0,    0, 0,    1, 1,  1,     1,   c_P,  1); // polarity flips: send
    vecs[5]  = mk(0, 0, 2'd0, 0,    0, 0,    1, 1,  1,     0,   c_P,  1); // single pulse only
    vecs[6]  = mk(1, 0, 2'd3, 0,    0, 0,    0, 0,  0,     0,   c_P,  1); // out status = 0
    vecs[7]  = mk(1, 1, 2'd2, c_P2, 0, 0,    0, 0,  0,     0,   c_P,  1); // store P2 (VC=1)
    vecs[8]  = mk(1, 1, 2'd2, c_A,  0, 0,    0, 0,  0,     0,   c_P,  1); // store while full: dropped
    vecs[9]  = mk(1, 0, 2'd3, 0,    0, 0,    0, 0,  1,     0,   c_P,  1);
    vecs[10] = mk(0, 0, 2'd0, 0,    0, 0,    1, 1,  1,     0,   c_P,  1); // VC=1, pol=1: hold
    vecs[11] = mk(0, 0, 2'd0, 0,    0, 0,    1, 0,  1,     1,   c_P2, 1); // original P2 leaves
    vecs[12] = mk(1, 1, 2'd2, c_A,  0, 0,    0, 0,  1,     0,   c_P2, 1); // store right after send
    vecs[13] = mk(0, 0, 2'd0, 0,    0, 0,    1, 1,  1,     1,   c_A,  1);
    vecs[14] = mk(0, 0, 2'd0, 0,    1, c_D,  0, 0,  1,     0,   c_A,  0); // arrival
    vecs[15] = mk(1, 0, 2'd1, 0,    1, c_F,  0, 0,  1,     0,   c_A,  0); // in status = 1, 0x55 blocked
    vecs[16] = mk(1, 0, 2'd0, 0,    1, c_F,  0, 0,  c_D,   0,   c_A,  1); // drain; arrival still blocked
    vecs[17] = mk(1, 0, 2'd1, 0,    1, c_F,  0, 0,  0,     0,   c_A,  0); // pre-edge status 0; 0x55 taken
    vecs[18] = mk(1, 0, 2'd0, 0,    0, 0,    0, 0,  c_F,   0,   c_A,  1);
    vecs[19] = mk(1, 0, 2'd0, 0,    0, 0,    0, 0,  c_F,   0,   c_A,  1); // empty read: stale data
    vecs[20] = mk(1, 0, 2'd2, 0,    0, 0,    0, 0,  0,     0,   c_A,  1); // addr 10 reads 0
    vecs[21] = mk(1, 1, 2'd0, c_X,  0, 0,    0, 0,  0,     0,   c_A,  1); // store to 00 ignored
    vecs[22] = mk(1, 0, 2'd0, 0,    0, 0,    0, 0,  c_F,   0,   c_A,  1); // in_buf untouched
    vecs[23] = mk(0, 0, 2'd1, 0,    0, 0,    0, 0,  c_F,   0,   c_A,  1); // nicEn=0: d_out holds
    vecs[24] = mk(1, 1, 2'd3, 1,    0, 0,    0, 0,  c_F,   0,   c_A,  1); // store to 11 ignored
    vecs[25] = mk(1, 0, 2'd3, 0,    0, 0,    0, 0,  0,     0,   c_A,  1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset d_out",  d_out,         64'd0);
    chk("reset net_so", {63'd0, net_so}, 64'd0);
    chk("reset net_do", net_do,        64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset net_ri", {63'd0, net_ri}, 64'd1);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].wr, vecs[i].a, vecs[i].din,
            vecs[i].si, vecs[i].di, vecs[i].ro, vecs[i].pol);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d d_out", i),  d_out,            vecs[i].e_dout);
      chk($sformatf("v%0d net_so", i), {63'd0, net_so},  {63'd0, vecs[i].e_so});
      chk($sformatf("v%0d net_do", i), net_do,           vecs[i].e_do);
      chk($sformatf("v%0d net_ri", i), {63'd0, net_ri},  {63'd0, vecs[i].e_ri});
    end

    // Fill both buffers, then hit rst between clock edges.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd2, c_P, 1'b1, c_D, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("full d_out",  d_out,            64'd1);
    chk("full net_ri", {63'd0, net_ri},  64'd0);
    drive(1'b0, 1'b0, 2'd0, '0, 1'b0, '0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async d_out",  d_out,           64'd0);
    chk("async net_so", {63'd0, net_so}, 64'd0);
    chk("async net_do", net_do,          64'd0);
    chk("async net_ri", {63'd0, net_ri}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Router ready with a favourable polarity: a lost packet must not leave.
    drive(1'b1, 1'b0, 2'd1, '0, 1'b0, '0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("post-rst in status", d_out,          64'd0);
    chk("post-rst net_so",    {63'd0, net_so}, 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd3, '0, 1'b0, '0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("post-rst out status", d_out,           64'd0);
    chk("post-rst net_so 2",   {63'd0, net_so}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
